// File: rtl/alu_muldiv_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL/MULHU and, with
// ALU_MULDIV_DIV_EN defined, restoring DIVU/REMU. Valid/ready on both sides.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             OverFlow,
  output logic             Zero,
  output logic             Negative
);
  // state  | meaning
  // S_IDLE | waiting for an op, in_ready=1
  // S_BUSY | one mul/div iteration per cycle, cnt counts down to 0
  // S_DONE | result held, out_valid=1 until out_ready
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hi_q, hi_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 carry_q, carry_d, ov_q, ov_d, zero_q, zero_d, neg_q, neg_d;
  logic                 out_valid_q, out_valid_d;

  logic [WIDTH:0]       add_full, sub_full, mul_sum;
  logic                 add_ov, sub_ov;
  logic [2*WIDTH-1:0]   prod_nx;
  logic                 fin, fin_carry, fin_ov;
  logic [WIDTH-1:0]     fin_res;

  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ov   = (A[WIDTH-1] == B[WIDTH-1]) & (add_full[WIDTH-1] != A[WIDTH-1]);
  assign sub_ov   = (A[WIDTH-1] != B[WIDTH-1]) & (sub_full[WIDTH-1] != A[WIDTH-1]);

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{prod_q[0]}} & a_q};
  assign prod_nx = {mul_sum, prod_q[WIDTH-1:1]};

`ifdef ALU_MULDIV_DIV_EN
  logic                 div_q, div_d;
  logic [WIDTH-1:0]     b_q, b_d, rem_q, rem_d, quo_q, quo_d, rem_nx, quo_nx;
  logic [WIDTH:0]       div_trial;
  logic                 div_ge;

  // B==0 falls out naturally: every trial succeeds, giving all-ones quotient and rem=A.
  assign div_trial = {rem_q, quo_q[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, b_q};
  assign rem_nx    = div_trial[WIDTH-1:0] - ({WIDTH{div_ge}} & b_q);
  assign quo_nx    = {quo_q[WIDTH-2:0], div_ge};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    a_d         = a_q;
    prod_d      = prod_q;
    res_d       = res_q;
    carry_d     = carry_q;
    ov_d        = ov_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    fin         = 1'b0;
    fin_res     = '0;
    fin_carry   = 1'b0;
    fin_ov      = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
    div_d = div_q;
    b_d   = b_q;
    rem_d = rem_q;
    quo_d = quo_q;
`endif
    case (state_q)
      S_IDLE: if (in_valid) begin
        hi_d = ALUControl[0];
        fin  = 1'b1;
        case (ALUControl)
          OP_ADD: begin
            fin_res   = add_full[WIDTH-1:0];
            fin_carry = add_full[WIDTH];
            fin_ov    = add_ov;
          end
          OP_SUB: begin
            fin_res   = sub_full[WIDTH-1:0];
            fin_carry = sub_full[WIDTH];
            fin_ov    = sub_ov;
          end
          OP_AND: fin_res = A & B;
          OP_OR:  fin_res = A | B;
          OP_XOR: fin_res = A ^ B;
          OP_SLT: fin_res = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ov};
          OP_MUL, OP_MULHU: begin
            fin     = 1'b0;
            state_d = S_BUSY;
            cnt_d   = CNT_W'(WIDTH - 1);
            a_d     = A;
            prod_d  = {{WIDTH{1'b0}}, B};
`ifdef ALU_MULDIV_DIV_EN
            div_d   = 1'b0;
`endif
          end
`ifdef ALU_MULDIV_DIV_EN
          OP_DIVU, OP_REMU: begin
            fin     = 1'b0;
            state_d = S_BUSY;
            cnt_d   = CNT_W'(WIDTH - 1);
            div_d   = 1'b1;
            b_d     = B;
            quo_d   = A;
            rem_d   = '0;
          end
`endif
          default: fin_res = '0;
        endcase
      end
      S_BUSY: begin
        cnt_d   = cnt_q - CNT_W'(1);
        prod_d  = prod_nx;
        fin_res = hi_q ? prod_nx[2*WIDTH-1:WIDTH] : prod_nx[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (div_q) fin_res = hi_q ? rem_nx : quo_nx;
`endif
        fin = (cnt_q == '0);
      end
      S_DONE: if (out_ready) begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // Result and flags are only ever written on entry to DONE.
    if (fin) begin
      state_d     = S_DONE;
      out_valid_d = 1'b1;
      res_d       = fin_res;
      carry_d     = fin_carry;
      ov_d        = fin_ov;
      zero_d      = (fin_res == '0);
      neg_d       = fin_res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_q        <= 1'b0;
      a_q         <= '0;
      prod_q      <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      ov_q        <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      div_q       <= 1'b0;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      a_q         <= a_d;
      prod_q      <= prod_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      ov_q        <= ov_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_MULDIV_DIV_EN
      div_q       <= div_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign Result    = res_q;
  assign Carry     = carry_q;
  assign OverFlow  = ov_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq (WIDTH=32); expectations follow ALU_MULDIV_DIV_EN.
module tb_alu_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] A = '0, B = '0, Result;
  logic [3:0]  ALUControl = '0;
  logic        Carry, OverFlow, Zero, Negative;
  int          n_chk = 0, n_err = 0;

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Carry(Carry), .OverFlow(OverFlow),
    .Zero(Zero), .Negative(Negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after acceptance, measure latency, check result and {C,V,Z,N}.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] exp_res,
                        input logic [3:0] exp_f, input bit rel);
    int   cyc;
    logic rdy_seen;
    @(negedge clk);
    chk({tag, "/in_ready"}, 64'(in_ready), 1);
    A = a; B = b; ALUControl = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; ALUControl = 4'($urandom);
    cyc = 1;
    rdy_seen = in_ready;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      rdy_seen |= in_ready;
    end
    chk({tag, "/lat"}, 64'(cyc), 64'(lat));
    chk({tag, "/busy_rdy"}, 64'(rdy_seen), 0);
    chk({tag, "/res"}, 64'(Result), 64'(exp_res));
    chk({tag, "/flags"}, 64'({Carry, OverFlow, Zero, Negative}), 64'(exp_f));
    if (rel) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      chk({tag, "/idle"}, 64'({out_valid, in_ready}), 2'b01);
    end
  endtask

  initial begin
    logic bad;
    #1;
    chk("rst/state", 64'({out_valid, in_ready}), 2'b01);
    chk("rst/res", 64'(Result), 0);
    chk("rst/flags", 64'({Carry, OverFlow, Zero, Negative}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // out_ready with nothing pending must do nothing.
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_oready", 64'({out_valid, in_ready, Result}), 64'({2'b01, 32'h0}));
    out_ready = 1'b0;

    run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1,        1, 32'h0,        4'b1010, 1);
    run_op("add_ovf",  4'b0000, 32'h7FFF_FFFF, 32'h1,        1, 32'h8000_0000, 4'b0101, 1);
    run_op("sub_ovf",  4'b0001, 32'h8000_0000, 32'h1,        1, 32'h7FFF_FFFF, 4'b1100, 1);
    run_op("sub_brw",  4'b0001, 32'h1,         32'h2,        1, 32'hFFFF_FFFF, 4'b0001, 1);
    run_op("and",      4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0, 4'b0000, 1);
    run_op("or",       4'b0011, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1, 32'hFFFF_FFFF, 4'b0001, 1);
    run_op("xor",      4'b0100, 32'hAAAA_5555, 32'hAAAA_5555, 1, 32'h0,        4'b0010, 1);
    run_op("slt_neg",  4'b0101, 32'hFFFF_FFFF, 32'h1,        1, 32'h1,        4'b0000, 1);
    run_op("slt_no",   4'b0101, 32'h1,         32'hFFFF_FFFF, 1, 32'h0,        4'b0010, 1);
    run_op("slt_ovf",  4'b0101, 32'h8000_0000, 32'h7FFF_FFFF, 1, 32'h1,        4'b0000, 1);
    run_op("undef",    4'b0110, 32'h5,         32'h3,        1, 32'h0,        4'b0010, 1);

    run_op("mul",      4'b1000, 32'h1_0000,    32'h1_0000,   33, 32'h0,        4'b0010, 1);
    run_op("mulhu",    4'b1001, 32'h1_0000,    32'h1_0000,   33, 32'h1,        4'b0000, 1);
    run_op("mul_ff",   4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1,       4'b0000, 1);
    run_op("mulhu_ff", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 4'b0001, 1);
    run_op("mul_mix",  4'b1000, 32'h1234,      32'h5678,     33, 32'h0626_0060, 4'b0000, 1);

`ifdef ALU_MULDIV_DIV_EN
    run_op("divu",     4'b1100, 32'd100, 32'd7, 33, 32'd14,        4'b0000, 1);
    run_op("remu",     4'b1101, 32'd100, 32'd7, 33, 32'd2,         4'b0000, 1);
    run_op("divu_z",   4'b1100, 32'd5,   32'd0, 33, 32'hFFFF_FFFF, 4'b0001, 1);
    run_op("remu_z",   4'b1101, 32'd5,   32'd0, 33, 32'd5,         4'b0000, 1);
`else
    run_op("divu_off", 4'b1100, 32'd100, 32'd7, 1, 32'h0, 4'b0010, 1);
    run_op("remu_off", 4'b1101, 32'd5,   32'd0, 1, 32'h0, 4'b0010, 1);
`endif

    // Backpressure: hold the MUL result for 10 cycles.
    run_op("bp_mul", 4'b1000, 32'd3, 32'd5, 33, 32'd15, 4'b0000, 0);
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || Result !== 32'd15 ||
          {Carry, OverFlow, Zero, Negative} !== 4'b0000) bad = 1'b1;
    end
    chk("bp_hold", 64'(bad), 0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_release", 64'({out_valid, in_ready}), 2'b01);

    // Abort a long op with rst just before iteration 16.
    @(negedge clk);
`ifdef ALU_MULDIV_DIV_EN
    ALUControl = 4'b1100;
`else
    ALUControl = 4'b1000;
`endif
    A = 32'd100; B = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("abort/busy", 64'({out_valid, in_ready}), 2'b00);
    rst = 1'b1;
    #1;
    chk("abort/out_valid", 64'(out_valid), 0);
    chk("abort/res", 64'(Result), 0);
    chk("abort/flags", 64'({Carry, OverFlow, Zero, Negative}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) bad = 1'b1;
    end
    chk("abort/no_pulse", 64'(bad), 0);
    run_op("add_after", 4'b0000, 32'd2, 32'd3, 1, 32'd5, 4'b0000, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1);
  end
endmodule
